// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side (and future read-side) schedulers.
//   state_t / ST_*   : two-state grant FSM encoding (IDLE, BUSY)
//   DEFAULT_DATA_WIDTH: default word width, matches the dual-clock FIFO
//   idx_width()      : clog2-based width for index and counter registers
package fifo_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Width able to hold the values 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer-side and FIFO-side signals around the write arbiter.
//   req/req_data/ack : producer handshake (word moves when req[i] && ack[i])
//   full/w_en/w_data : FIFO write port, write clock domain
//   busy/owner       : grant status
// master = arbiter side, slave = producers + FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
);
    import fifo_pkg::*;

    localparam int OWNER_W = idx_width(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            ack;
    logic                          full;
    logic                          w_en;
    logic [DATA_WIDTH-1:0]         w_data;
    logic                          busy;
    logic [OWNER_W-1:0]            owner;

    modport master (
        input  req, req_data, full,
        output ack, w_en, w_data, busy, owner
    );

    modport slave (
        output req, req_data, full,
        input  ack, w_en, w_data, busy, owner
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority search.
//   req   : request vector
//   last  : index of the most recent grantee
//   valid : at least one request is set
//   idx   : first set request searching last+1, last+2, ... (mod N);
//           'last' itself is searched last so a lone requester is re-picked.
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         valid,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Walk from the farthest candidate back to the nearest so the nearest
    // set request after 'last' is the one left in idx.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = N; k >= 1; k--) begin
            cand = W'((int'(last) + k) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-limited arbiter sharing the FIFO write
// port among NUM_REQ producers.
//   clk  : write-domain clock (same net as FIFO w_clk)
//   rst  : asynchronous active-high reset
//   bus  : fifo_wr_arbiter_if.master (req, req_data, ack, full, w_en,
//          w_data, busy, owner)
// A grant ends when the owner drops req or after MAX_BURST accepted words;
// every release passes through one IDLE cycle. full only stalls the owner,
// it never causes rotation.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = 4
) (
    input  logic                clk,
    input  logic                rst,
    fifo_wr_arbiter_if.master   bus
);

    localparam int OWNER_W = idx_width(NUM_REQ);
    localparam int BEAT_W  = idx_width(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    state_t              state_reg, state_next;
    logic [OWNER_W-1:0]  owner_reg, owner_next;
    logic [BEAT_W-1:0]   beat_cnt_reg, beat_cnt_next;

    logic                pick_valid;
    logic [OWNER_W-1:0]  pick_idx;
    logic                transfer;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (bus.req),
        .last  (owner_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Unpack the flattened producer data and build the one-hot ack. The ack
    // depends on state_reg, so an asynchronous reset drops it immediately.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_prod
        assign words[gi]   = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign bus.ack[gi] = (state_reg == ST_BUSY) && (owner_reg == OWNER_W'(gi))
                             && bus.req[gi] && !bus.full;
    end

    assign transfer   = |bus.ack;
    assign bus.w_en   = transfer;
    assign bus.w_data = words[owner_reg];
    assign bus.busy   = (state_reg == ST_BUSY);
    assign bus.owner  = owner_reg;

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next    = ST_BUSY;
                    owner_next    = pick_idx;
                    beat_cnt_next = '0;
                end
            end
            default: begin
                if (!bus.req[owner_reg]) begin
                    state_next = ST_IDLE;
                end else if (transfer) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == LAST_BEAT) begin
                        state_next = ST_IDLE;
                    end
                end
                // req high with full high: stall, nothing changes
            end
        endcase
    end

    // owner resets to the last index so producer 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= OWNER_W'(NUM_REQ - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

endmodule
